// File: rtl/rgb_to_gray_pipe.sv
// rgb_to_gray_pipe: three-stage RGB-to-grayscale converter with valid/ready
// streams on both sides, an end-of-frame flag carried with each pixel, an
// output pixel counter and a one-cycle frame-done pulse.
// Build option: define GRAY_ROUND_EN to round to nearest (halves up);
// leave it undefined to truncate. Timing is identical in both builds.
module rgb_to_gray_pipe #(
    parameter int unsigned CH_W   = 4,
    parameter int unsigned FRAC_W = 8,
    parameter int unsigned COEF_R = 77,
    parameter int unsigned COEF_G = 150,
    parameter int unsigned COEF_B = 29,
    parameter int unsigned CNT_W  = 17
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [3*CH_W-1:0] rgb_in_i,
    input  logic              in_last_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CH_W-1:0]   gray_out_o,
    output logic              out_last_o,
    output logic [CNT_W-1:0]  pix_cnt_o,
    output logic              frame_done_o
);

    localparam int unsigned COEF_W = FRAC_W + 2;
    localparam int unsigned PROD_W = CH_W + FRAC_W + 2;
    localparam int unsigned SUM_W  = CH_W + FRAC_W + 4;
    // One spare bit so adding the rounding constant can never wrap.
    localparam int unsigned RSUM_W = SUM_W + 1;
    localparam int unsigned Q_W    = RSUM_W - FRAC_W;

    localparam logic [COEF_W-1:0] COEF_R_C = COEF_W'(COEF_R);
    localparam logic [COEF_W-1:0] COEF_G_C = COEF_W'(COEF_G);
    localparam logic [COEF_W-1:0] COEF_B_C = COEF_W'(COEF_B);
    localparam logic [CH_W-1:0]   GRAY_MAX = '1;

`ifdef GRAY_ROUND_EN
    localparam logic [RSUM_W-1:0] RND = RSUM_W'(1) << (FRAC_W - 1);
`endif

    // Stage 1: weighted channel products
    logic              s1Valid_q;
    logic              s1Last_q;
    logic [PROD_W-1:0] s1ProdR_q, s1ProdG_q, s1ProdB_q;
    logic [PROD_W-1:0] s1ProdR_d, s1ProdG_d, s1ProdB_d;

    // Stage 2: sum of products
    logic              s2Valid_q;
    logic              s2Last_q;
    logic [SUM_W-1:0]  s2Sum_q;
    logic [SUM_W-1:0]  s2Sum_d;

    // Stage 3: rounded, shifted, saturated result (drives the outputs)
    logic              s3Valid_q;
    logic              s3Last_q;
    logic [CH_W-1:0]   s3Gray_q;
    logic [CH_W-1:0]   s3Gray_d;
    logic [RSUM_W-1:0] roundSum;
    logic [Q_W-1:0]    quot;

    // Frame bookkeeping
    logic [CNT_W-1:0]  pixCnt_q;
    logic [CNT_W-1:0]  pixCnt_d;
    logic              frameDone_q;
    logic              frameDone_d;

    logic              adv;
    logic              outHs;
    logic [CH_W-1:0]   chR, chG, chB;

    // The whole pipe moves as one unit whenever the output slot is free or being drained.
    always_comb begin
        adv   = !s3Valid_q || out_ready_i;
        outHs = s3Valid_q && out_ready_i;
    end

    // Split the packed pixel and form the three weighted products.
    always_comb begin
        chR       = rgb_in_i[3*CH_W-1 -: CH_W];
        chG       = rgb_in_i[2*CH_W-1 -: CH_W];
        chB       = rgb_in_i[CH_W-1:0];
        s1ProdR_d = PROD_W'(chR) * PROD_W'(COEF_R_C);
        s1ProdG_d = PROD_W'(chG) * PROD_W'(COEF_G_C);
        s1ProdB_d = PROD_W'(chB) * PROD_W'(COEF_B_C);
    end

    // Sum the products; the sum width is chosen so it cannot overflow.
    always_comb begin
        s2Sum_d = SUM_W'(s1ProdR_q) + SUM_W'(s1ProdG_q) + SUM_W'(s1ProdB_q);
    end

    // Optional round, drop fractional bits, then clamp to the channel range.
    always_comb begin
`ifdef GRAY_ROUND_EN
        roundSum = RSUM_W'(s2Sum_q) + RND;
`else
        roundSum = RSUM_W'(s2Sum_q);
`endif
        quot     = Q_W'(roundSum >> FRAC_W);
        s3Gray_d = (quot > Q_W'(GRAY_MAX)) ? GRAY_MAX : quot[CH_W-1:0];
    end

    // Count accepted output pixels; the last pixel of a frame clears the count and fires the pulse.
    always_comb begin
        pixCnt_d    = pixCnt_q;
        frameDone_d = 1'b0;
        if (outHs) begin
            if (s3Last_q) begin
                pixCnt_d    = '0;
                frameDone_d = 1'b1;
            end else begin
                pixCnt_d    = pixCnt_q + CNT_W'(1);
            end
        end
    end

    // Pipeline and counter registers; reset flushes everything in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            s1Valid_q   <= 1'b0;
            s1Last_q    <= 1'b0;
            s1ProdR_q   <= '0;
            s1ProdG_q   <= '0;
            s1ProdB_q   <= '0;
            s2Valid_q   <= 1'b0;
            s2Last_q    <= 1'b0;
            s2Sum_q     <= '0;
            s3Valid_q   <= 1'b0;
            s3Last_q    <= 1'b0;
            s3Gray_q    <= '0;
            pixCnt_q    <= '0;
            frameDone_q <= 1'b0;
        end else begin
            pixCnt_q    <= pixCnt_d;
            frameDone_q <= frameDone_d;
            if (adv) begin
                s1Valid_q <= in_valid_i;
                s1Last_q  <= in_valid_i && in_last_i;
                s1ProdR_q <= s1ProdR_d;
                s1ProdG_q <= s1ProdG_d;
                s1ProdB_q <= s1ProdB_d;
                s2Valid_q <= s1Valid_q;
                s2Last_q  <= s1Last_q;
                s2Sum_q   <= s2Sum_d;
                s3Valid_q <= s2Valid_q;
                s3Last_q  <= s2Last_q;
                s3Gray_q  <= s3Gray_d;
            end
        end
    end

    assign in_ready_o   = adv;
    assign out_valid_o  = s3Valid_q;
    assign gray_out_o   = s3Gray_q;
    assign out_last_o   = s3Last_q;
    assign pix_cnt_o    = pixCnt_q;
    assign frame_done_o = frameDone_q;

endmodule

// File: tb/tb_rgb_to_gray_pipe.sv
// Testbench for rgb_to_gray_pipe: default instance, a saturating-weights
// instance and a narrow-counter instance, all fed the same stream.
module tb_rgb_to_gray_pipe;

`ifdef GRAY_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        inValid = 1'b0;
    logic        inLast = 1'b0;
    logic [11:0] inRgb = '0;
    logic        outReady = 1'b1;

    logic        inReady, outValid, outLast, frameDone;
    logic [3:0]  gray;
    logic [16:0] pixCnt;
    logic        satInReady, satOutValid, satOutLast, satFrameDone;
    logic [3:0]  satGray;
    logic [16:0] satPixCnt;
    logic        wInReady, wOutValid, wOutLast, wFrameDone;
    logic [3:0]  wGray;
    logic [2:0]  wPixCnt;

    always #5 clk = ~clk;

    rgb_to_gray_pipe dut (
        .clk_i(clk), .rst_n_i(rstN), .in_valid_i(inValid), .in_ready_o(inReady),
        .rgb_in_i(inRgb), .in_last_i(inLast), .out_valid_o(outValid),
        .out_ready_i(outReady), .gray_out_o(gray), .out_last_o(outLast),
        .pix_cnt_o(pixCnt), .frame_done_o(frameDone)
    );

    rgb_to_gray_pipe #(.COEF_R(200), .COEF_G(200), .COEF_B(200)) dutSat (
        .clk_i(clk), .rst_n_i(rstN), .in_valid_i(inValid), .in_ready_o(satInReady),
        .rgb_in_i(inRgb), .in_last_i(inLast), .out_valid_o(satOutValid),
        .out_ready_i(outReady), .gray_out_o(satGray), .out_last_o(satOutLast),
        .pix_cnt_o(satPixCnt), .frame_done_o(satFrameDone)
    );

    rgb_to_gray_pipe #(.CNT_W(3)) dutWrap (
        .clk_i(clk), .rst_n_i(rstN), .in_valid_i(inValid), .in_ready_o(wInReady),
        .rgb_in_i(inRgb), .in_last_i(inLast), .out_valid_o(wOutValid),
        .out_ready_i(outReady), .gray_out_o(wGray), .out_last_o(wOutLast),
        .pix_cnt_o(wPixCnt), .frame_done_o(wFrameDone)
    );

    typedef struct {
        logic [11:0] rgb;
        logic        last;
        int          gray;
        int          graySat;
    } vec_t;

    typedef struct {
        int   gray;
        int   graySat;
        logic last;
    } exp_t;

    vec_t vecs[6];
    exp_t sb[$];

    int vectors = 0;
    int miscompares = 0;
    int curGray = 0;
    int curSat = 0;
    bit mv1 = 0, mv2 = 0, mv3 = 0;
    bit madv;
    int cnt = 0, cntW = 0;
    bit fd = 0, fdW = 0;
    bit checkEn = 0;
    int readyMode = 0;
    int patIdx = 0;
    int framePulses = 0;
    exp_t popped;

    // Reference luma: weighted sum, optional round, shift by 8, clamp to 15.
    function automatic int refGray(input logic [11:0] rgb, input int cr, input int cg, input int cb);
        int s;
        int q;
        s = int'(rgb[11:8]) * cr + int'(rgb[7:4]) * cg + int'(rgb[3:0]) * cb;
        q = (s + (ROUND ? 128 : 0)) >> 8;
        return (q > 15) ? 15 : q;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one pixel and hold it until it is accepted (bounded wait).
    task automatic applyStimulus(input logic [11:0] rgb, input logic last, input int eg, input int es);
        bit accepted;
        inValid = 1'b1;
        inRgb   = rgb;
        inLast  = last;
        curGray = eg;
        curSat  = es;
        accepted = 1'b0;
        for (int k = 0; k < 60 && !accepted; k++) begin
            @(negedge clk);
            accepted = inReady;
            @(posedge clk);
            #1;
        end
        if (!accepted) checkOutput("accept_timeout", 0, 1);
        inValid = 1'b0;
        inLast  = 1'b1;
    endtask

    task automatic applyRandom(input logic last);
        logic [11:0] r;
        r = 12'($urandom);
        applyStimulus(r, last, refGray(r, 77, 150, 29), refGray(r, 200, 200, 200));
    endtask

    task automatic idleCycles(input int n);
        inValid = 1'b0;
        inLast  = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        inValid = 1'b0;
        while (sb.size() != 0 && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (sb.size() != 0) checkOutput("drain_timeout", sb.size(), 0);
    endtask

    // Output-side ready pattern generator.
    always @(posedge clk) begin
        #1;
        case (readyMode)
            0: outReady = 1'b1;
            1: begin
                outReady = (patIdx % 3 == 0);
                patIdx++;
            end
            2: outReady = 1'(($urandom_range(0, 3)) != 0);
            default: outReady = 1'b0;
        endcase
    end

    // Timing model and scoreboard: push on input handshake, pop on output handshake.
    always @(posedge clk) begin
        if (!rstN) begin
            mv1 = 0; mv2 = 0; mv3 = 0;
            sb.delete();
            cnt = 0; fd = 0; cntW = 0; fdW = 0;
        end else begin
            madv = !mv3 || outReady;
            fd = 0;
            fdW = 0;
            if (mv3 && outReady && sb.size() != 0) begin
                popped = sb.pop_front();
                if (popped.last) begin
                    cnt = 0; fd = 1; cntW = 0; fdW = 1;
                end else begin
                    cnt = (cnt + 1) % (1 << 17);
                    cntW = (cntW + 1) % 8;
                end
            end
            if (madv) begin
                mv3 = mv2;
                mv2 = mv1;
                mv1 = inValid;
                if (inValid) sb.push_back('{curGray, curSat, inLast});
            end
        end
    end

    // Compare every instance against the model away from the clock edge.
    always @(negedge clk) begin
        if (frameDone) framePulses++;
        if (checkEn) begin
            checkOutput("out_valid", int'(outValid), int'(mv3));
            checkOutput("in_ready", int'(inReady), int'(!mv3 || outReady));
            checkOutput("pix_cnt", int'(pixCnt), cnt);
            checkOutput("frame_done", int'(frameDone), int'(fd));
            checkOutput("sat_out_valid", int'(satOutValid), int'(mv3));
            checkOutput("sat_in_ready", int'(satInReady), int'(!mv3 || outReady));
            checkOutput("sat_pix_cnt", int'(satPixCnt), cnt);
            checkOutput("sat_frame_done", int'(satFrameDone), int'(fd));
            checkOutput("wrap_out_valid", int'(wOutValid), int'(mv3));
            checkOutput("wrap_in_ready", int'(wInReady), int'(!mv3 || outReady));
            checkOutput("wrap_pix_cnt", int'(wPixCnt), cntW);
            checkOutput("wrap_frame_done", int'(wFrameDone), int'(fdW));
            if (mv3 && sb.size() != 0) begin
                checkOutput("gray_out", int'(gray), sb[0].gray);
                checkOutput("out_last", int'(outLast), int'(sb[0].last));
                checkOutput("sat_gray_out", int'(satGray), sb[0].graySat);
                checkOutput("sat_out_last", int'(satOutLast), int'(sb[0].last));
                checkOutput("wrap_gray_out", int'(wGray), sb[0].gray);
                checkOutput("wrap_out_last", int'(wOutLast), int'(sb[0].last));
            end
        end
    end

    initial begin
        // Directed vectors: {rgb, last, expected gray, expected gray with all weights 200}
        vecs[0] = '{12'hF00, 1'b0, ROUND ? 5 : 4, ROUND ? 12 : 11};
        vecs[1] = '{12'h0F0, 1'b0, ROUND ? 9 : 8, ROUND ? 12 : 11};
        vecs[2] = '{12'h00F, 1'b0, ROUND ? 2 : 1, ROUND ? 12 : 11};
        vecs[3] = '{12'hFFF, 1'b0, 15, 15};
        vecs[4] = '{12'h000, 1'b0, 0, 0};
        vecs[5] = '{12'h123, 1'b0, ROUND ? 2 : 1, ROUND ? 5 : 4};

        rstN = 1'b0;
        @(posedge clk);
        #1;
        checkEn = 1'b1;
        @(posedge clk);
        #1;
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("rst_gray_out", int'(gray), 0);
        checkOutput("rst_out_last", int'(outLast), 0);
        checkOutput("rst_in_ready", int'(inReady), 1);
        @(posedge clk);
        #1;

        $display("[TB] back-to-back directed vectors");
        readyMode = 0;
        for (int i = 0; i < 6; i++) applyStimulus(vecs[i].rgb, vecs[i].last, vecs[i].gray, vecs[i].graySat);
        drain();

        $display("[TB] backpressure 1,0,0 pattern");
        patIdx = 0;
        readyMode = 1;
        for (int i = 0; i < 6; i++) applyRandom(1'b0);
        drain();
        readyMode = 0;
        idleCycles(2);

        $display("[TB] frame of 5, single-pixel frame, next frame");
        framePulses = 0;
        for (int i = 0; i < 5; i++) applyRandom(i == 4);
        drain();
        idleCycles(2);
        checkOutput("frame_pulses", framePulses, 1);
        applyRandom(1'b1);
        drain();
        idleCycles(2);
        checkOutput("single_frame_pulses", framePulses, 2);
        checkOutput("single_frame_cnt", int'(pixCnt), 0);
        applyRandom(1'b0);
        applyRandom(1'b0);
        drain();
        idleCycles(1);
        checkOutput("next_frame_cnt", int'(pixCnt), 2);

        $display("[TB] reset with three pixels in flight");
        readyMode = 3;
        idleCycles(1);
        for (int i = 0; i < 3; i++) applyRandom(1'b0);
        rstN = 1'b0;
        @(posedge clk);
        #1;
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("flush_out_valid", int'(outValid), 0);
        checkOutput("flush_pix_cnt", int'(pixCnt), 0);
        checkOutput("flush_in_ready", int'(inReady), 1);
        checkOutput("flush_gray_out", int'(gray), 0);
        @(posedge clk);
        #1;
        readyMode = 0;
        idleCycles(6);

        $display("[TB] narrow counter wrap, 9 pixels");
        for (int i = 0; i < 9; i++) applyRandom(1'b0);
        drain();
        idleCycles(1);
        checkOutput("wrap_cnt_final", int'(wPixCnt), 1);
        checkOutput("main_cnt_final", int'(pixCnt), 9);

        $display("[TB] random stream with random backpressure");
        readyMode = 2;
        for (int i = 0; i < 40; i++) begin
            applyRandom(1'($urandom_range(0, 4) == 0));
            if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 2));
        end
        drain();
        readyMode = 0;
        idleCycles(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
